net_sequencer: RTL
==================

NET_SEQUENCER -- requirements
Module: net_sequencer

Interface
REQ-001 Parameter WS, default 16, width of the control-signal word driven to the PU network.
REQ-002 Parameter DEPTH, default 16, number of program words; power of two.
REQ-003 Parameter WPC, default 4, program-counter width, log2(DEPTH).
REQ-004 Parameter OE_MASK, default 16'h8080, marks the bits of the control word that are bus output-enables.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 prog_we  in  1  program write strobe.
REQ-008 prog_addr  in  WPC  program write address.
REQ-009 prog_data  in  WS+1  program word: [WS] last flag, [WS-1:0] control word.
REQ-010 start  in  1  single-cycle request to begin program execution at address 0.
REQ-011 stop  in  1  request to end execution.
REQ-012 loop  in  1  1 restarts at address 0 after the last word; 0 returns to IDLE.
REQ-013 clear  in  1  clears the ERR state.
REQ-014 signals  out  WS  registered control word to the PU network.
REQ-015 pc  out  WPC  address of the word currently on signals.
REQ-016 busy  out  1  high in RUN.
REQ-017 pass_done  out  1  one-cycle pulse in the cycle after the last word has been presented.
REQ-018 err  out  1  high in ERR; bus conflict detected.

Function
REQ-019 The program memory shall hold DEPTH words of WS+1 bits; contents are not reset.
REQ-020 A write shall occur on a clk edge with prog_we=1, only when the state is IDLE or ERR; prog_we in RUN is ignored.
REQ-021 The block shall have three states: IDLE, RUN, ERR.
REQ-022 IDLE: signals=0, busy=0; start=1 and stop=0 -> RUN, and the next edge presents mem[0] on signals with pc=0.
REQ-023 RUN: each edge advances pc by 1 and presents mem[pc+1]; one word is presented per cycle with no gaps.
REQ-024 A word whose last flag is set, or the word at pc=DEPTH-1, ends a pass; wrap-around from DEPTH-1 to 0 happens only through this rule.
REQ-025 End of pass with loop=1: the next edge presents mem[0], pc=0, and pass_done pulses in that cycle.
REQ-026 End of pass with loop=0: the next edge enters IDLE with signals=0, and pass_done pulses in that cycle.
REQ-027 stop=1 in RUN: the next edge enters IDLE, signals=0, pass_done=0, and the current word is not repeated.
REQ-028 start and stop asserted together: stop wins; in IDLE the block stays in IDLE.
REQ-029 start in RUN shall be ignored.
REQ-030 Conflict check: before presentation, each fetched word is tested; popcount(word & OE_MASK) > 1 is a conflict.
REQ-031 A conflicting word shall never appear on signals; that edge enters ERR with signals=0, err=1, busy=0, and pc holding the faulting address.
REQ-032 ERR: clear=1 -> IDLE on the next edge, err=0; start is ignored until err has been cleared.
REQ-033 pass_done and err shall be mutually exclusive in any cycle.

Reset
REQ-034 rst=0 shall immediately force IDLE, signals=0, pc=0, busy=0, pass_done=0, err=0, regardless of clk, including mid-RUN.
REQ-035 After rst rises, the first start shall begin at address 0.

Verification
REQ-036 Load mem[0..3]={8000,4000,0080,8000|last}, loop=0, start -> signals 8000,4000,0080,8000 on consecutive cycles, then 0; pass_done high exactly once; busy high for 4 cycles.
REQ-037 Same program with loop=1, run 10 cycles -> pc sequence 0,1,2,3,0,1,2,3,0,1; pass_done pulses at cycles 5 and 9.
REQ-038 mem[2]=8080 (two OE bits) -> signals 8000,4000, then 0; err=1, pc=2; start ignored; clear -> IDLE, err=0.
REQ-039 stop asserted while pc=1 -> next cycle signals=0, busy=0, no pass_done; start and stop asserted together in IDLE -> stays IDLE.
REQ-040 No last flag anywhere, loop=0 -> DEPTH words presented, then IDLE; prog_we during RUN leaves memory unchanged on a later readback run.
REQ-041 rst pulled low asynchronously mid-RUN, between clock edges -> signals=0 and busy=0 before the next edge.

Source files
------------

// File: rtl/net_sequencer.sv
// Microcode sequencer: plays a loaded program of control words onto the PU network,
// one word per cycle, and refuses to drive any word that would enable two bus drivers.
module net_sequencer #(
  parameter int              WS      = 16,
  parameter int              DEPTH   = 16,
  parameter int              WPC     = 4,
  parameter logic [WS-1:0]   OE_MASK = 16'h8080
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           prog_we,
  input  logic [WPC-1:0] prog_addr,
  input  logic [WS:0]    prog_data,
  input  logic           start,
  input  logic           stop,
  input  logic           loop,
  input  logic           clear,
  output logic [WS-1:0]  signals,
  output logic [WPC-1:0] pc,
  output logic           busy,
  output logic           pass_done,
  output logic           err
);

  typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

  state_t         state_q, state_d;
  logic [WPC-1:0] pc_q, pc_d;
  logic [WS-1:0]  signals_q, signals_d;
  logic           pass_done_q, pass_done_d;

  logic [WS:0]    mem [DEPTH];
  logic [WPC-1:0] fetch_addr;
  logic [WS:0]    fetch_word;
  logic           end_of_pass;
  logic           conflict;

  function automatic int unsigned popcount(input logic [WS-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < WS; i++) n = n + 32'(v[i]);
    return n;
  endfunction

  // NOTE: program storage has no reset; it is plain RAM and software reloads it.
  always_ff @(posedge clk) begin
    if (prog_we && state_q != RUN) mem[prog_addr] <= prog_data;
  end

  // The word on signals ends the pass if it carries the last flag or sits at the top.
  assign end_of_pass = mem[pc_q][WS] || (pc_q == WPC'(DEPTH - 1));

  always_comb begin
    fetch_addr = '0;
    if (state_q == RUN && !end_of_pass) fetch_addr = pc_q + WPC'(1);
  end

  assign fetch_word = mem[fetch_addr];
  assign conflict   = popcount(fetch_word[WS-1:0] & OE_MASK) > 1;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    signals_d   = signals_q;
    pass_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        signals_d = '0;
        if (start && !stop) begin
          pc_d = '0;
          if (conflict) begin
            state_d = ERR;
          end else begin
            state_d   = RUN;
            signals_d = fetch_word[WS-1:0];
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_d   = IDLE;
          pc_d      = '0;
          signals_d = '0;
        end else if (end_of_pass && !loop) begin
          state_d     = IDLE;
          pc_d        = '0;
          signals_d   = '0;
          pass_done_d = 1'b1;
        end else begin
          pc_d = fetch_addr;
          if (conflict) begin
            // Faulting address stays on pc; pass_done is suppressed so it never overlaps err.
            state_d   = ERR;
            signals_d = '0;
          end else begin
            signals_d   = fetch_word[WS-1:0];
            pass_done_d = end_of_pass;
          end
        end
      end
      ERR: begin
        signals_d = '0;
        if (clear) begin
          state_d = IDLE;
          pc_d    = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        pc_d      = '0;
        signals_d = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      signals_q   <= '0;
      pass_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      signals_q   <= signals_d;
      pass_done_q <= pass_done_d;
    end
  end

  assign signals   = signals_q;
  assign pc        = pc_q;
  assign pass_done = pass_done_q;
  assign busy      = (state_q == RUN);
  assign err       = (state_q == ERR);

endmodule
